mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/rv_ctrl_pkg.sv | 63 ++++++
 rtl/mc_controller_if.sv | 34 +++
 rtl/instr_dec.sv | 38 +++
 rtl/mc_controller.sv | 156 +++++++++++++++
 tb/tb_mc_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared opcode constants, state encoding and control-field codes for the
// multicycle RISC-V controller.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_instr;
    logic       instr_done;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller side is the
// master; the datapath side is the slave.
interface mc_controller_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       pc_update;
  logic       branch;
  logic       reg_write;
  logic       mem_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       illegal_instr;
  logic       instr_done;

  modport master (
    input  op, mem_ready,
    output mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write,
           alu_src_a, alu_src_b, result_src, alu_op, imm_src,
           illegal_instr, instr_done
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, adr_src, ir_write, pc_update, branch, reg_write, mem_write,
           alu_src_a, alu_src_b, result_src, alu_op, imm_src,
           illegal_instr, instr_done
  );
endinterface

// File: rtl/instr_dec.sv
// Opcode decoder: immediate format selection and legality, with the I-type
// ALU and jal opcodes individually removable.
module instr_dec
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_IALU = 1'b1,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src,
  output logic       o_legal
);

  always_comb begin
    o_imm_src = IMM_I;
    o_legal   = 1'b0;
    case (i_op)
      OP_LOAD:   o_legal = 1'b1;
      OP_STORE: begin
        o_imm_src = IMM_S;
        o_legal   = 1'b1;
      end
      OP_RTYPE:  o_legal = 1'b1;
      OP_ITYPE:  o_legal = ENABLE_IALU;
      OP_BRANCH: begin
        o_imm_src = IMM_B;
        o_legal   = 1'b1;
      end
      OP_JAL: begin
        // imm_src tracks the opcode even when jal is compiled out
        o_imm_src = IMM_J;
        o_legal   = ENABLE_JAL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM. All control outputs except imm_src are forced
// low while rst_n is low.
//   state    | meaning
//   FETCH    | read instruction at PC, wait for mem_ready
//   DECODE   | PC-relative target, select path by opcode
//   MEMADR   | compute load/store address
//   MEMREAD  | load data read, wait for mem_ready
//   MEMWB    | write load data to register file
//   MEMWRITE | store data write, wait for mem_ready
//   EXECR/I  | ALU operation, register / immediate operand
//   ALUWB    | write ALU result to register file
//   BEQ      | compare and branch
//   JAL      | jump, link value written in ALUWB
module mc_controller
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_IALU = 1'b1,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_controller_if.master bus
);

  state_e     r_state;
  state_e     w_state_nxt;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrl_out;
  logic       w_legal;
  logic [1:0] w_imm_src;

  instr_dec #(
    .ENABLE_IALU(ENABLE_IALU),
    .ENABLE_JAL (ENABLE_JAL)
  ) u_dec (
    .i_op     (bus.op),
    .o_imm_src(w_imm_src),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_FETCH;
    w_ctrl      = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = 1'b0;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURES;
        w_ctrl.ir_write   = bus.mem_ready;
        w_ctrl.pc_update  = bus.mem_ready;
        w_state_nxt       = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        if (!w_legal) begin
          w_ctrl.illegal_instr = 1'b1;
        end else begin
          case (bus.op)
            OP_LOAD, OP_STORE: w_state_nxt = S_MEMADR;
            OP_RTYPE:          w_state_nxt = S_EXECR;
            OP_ITYPE:          w_state_nxt = S_EXECI;
            OP_BRANCH:         w_state_nxt = S_BEQ;
            OP_JAL:            w_state_nxt = S_JAL;
            default:           w_state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_state_nxt      = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.adr_src = 1'b1;
        w_state_nxt    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.instr_done = bus.mem_ready;
        w_state_nxt       = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_RD2;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_state_nxt      = S_ALUWB;
      end
      S_EXECI: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_FUNCT;
        w_state_nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a  = SRCA_RD1;
        w_ctrl.alu_src_b  = SRCB_RD2;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.branch     = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        // completion is reported by the ALUWB that writes the link register
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_update  = 1'b1;
        w_state_nxt       = S_ALUWB;
      end
      default: ;
    endcase
  end

  assign w_ctrl_out = rst_n ? w_ctrl : '0;

  assign bus.mem_req       = w_ctrl_out.mem_req;
  assign bus.adr_src       = w_ctrl_out.adr_src;
  assign bus.ir_write      = w_ctrl_out.ir_write;
  assign bus.pc_update     = w_ctrl_out.pc_update;
  assign bus.branch        = w_ctrl_out.branch;
  assign bus.reg_write     = w_ctrl_out.reg_write;
  assign bus.mem_write     = w_ctrl_out.mem_write;
  assign bus.illegal_instr = w_ctrl_out.illegal_instr;
  assign bus.instr_done    = w_ctrl_out.instr_done;
  assign bus.alu_src_a     = w_ctrl_out.alu_src_a;
  assign bus.alu_src_b     = w_ctrl_out.alu_src_b;
  assign bus.result_src    = w_ctrl_out.result_src;
  assign bus.alu_op        = w_ctrl_out.alu_op;
  assign bus.imm_src       = w_imm_src;

endmodule

// File: tb/tb_mc_controller.sv
// Cycle-by-cycle check of mc_controller against an instruction-level model
// that expands each instruction into its phase sequence.
module tb_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EXR, P_EXI, P_AWB, P_BEQ, P_JAL} phase_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   sel   = 1'b0;

  always #5 clk = ~clk;

  mc_controller_if bus0 ();
  mc_controller_if bus1 ();

  mc_controller dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  mc_controller #(.ENABLE_IALU(1'b0), .ENABLE_JAL(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  logic [18:0] w_out0, w_out1;
  assign w_out0 = {bus0.mem_req, bus0.adr_src, bus0.ir_write, bus0.pc_update, bus0.branch,
                   bus0.reg_write, bus0.mem_write, bus0.illegal_instr, bus0.instr_done,
                   bus0.alu_src_a, bus0.alu_src_b, bus0.result_src, bus0.alu_op, bus0.imm_src};
  assign w_out1 = {bus1.mem_req, bus1.adr_src, bus1.ir_write, bus1.pc_update, bus1.branch,
                   bus1.reg_write, bus1.mem_write, bus1.illegal_instr, bus1.instr_done,
                   bus1.alu_src_a, bus1.alu_src_b, bus1.result_src, bus1.alu_op, bus1.imm_src};

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (dut%0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic legal(input logic [6:0] o);
    case (o)
      LW, SW, RT, BQ: return 1'b1;
      IT, JL:         return !sel;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] imm_model(input logic [6:0] o);
    case (o)
      SW:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Outputs per phase: {mem_req,adr_src,ir_write,pc_update,branch,reg_write,
  // mem_write,illegal,done, src_a, src_b, result_src, alu_op}
  function automatic logic [16:0] phase_out(input phase_e p, input logic rdy, input logic [6:0] o);
    logic mr, as, ir, pu, br, rw, mw, il, dn;
    logic [1:0] a, b, rs, ao;
    {mr, as, ir, pu, br, rw, mw, il, dn} = '0;
    {a, b, rs, ao} = '0;
    case (p)
      P_F:   begin mr = 1; ir = rdy; pu = rdy; b = 2'b10; rs = 2'b10; end
      P_D:   begin a = 2'b01; b = 2'b01; il = !legal(o); end
      P_MA:  begin a = 2'b10; b = 2'b01; end
      P_MR:  begin mr = 1; as = 1; end
      P_MWB: begin rs = 2'b01; rw = 1; dn = 1; end
      P_MW:  begin mr = 1; as = 1; mw = 1; dn = rdy; end
      P_EXR: begin a = 2'b10; ao = 2'b10; end
      P_EXI: begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      P_AWB: begin rw = 1; dn = 1; end
      P_BEQ: begin a = 2'b10; ao = 2'b01; br = 1; dn = 1; end
      P_JAL: begin a = 2'b01; b = 2'b10; pu = 1; end
      default: ;
    endcase
    return {mr, as, ir, pu, br, rw, mw, il, dn, a, b, rs, ao};
  endfunction

  task automatic cyc(input phase_e p, input logic [6:0] opv, input logic rdy,
                     input logic rstn, input string tag);
    logic [18:0] exp;
    @(negedge clk);
    rst_n = rstn;
    if (sel) begin bus1.op = opv; bus1.mem_ready = rdy; end
    else     begin bus0.op = opv; bus0.mem_ready = rdy; end
    exp = rstn ? {phase_out(p, rdy, opv), imm_model(opv)} : {17'b0, imm_model(opv)};
    #2;
    chk(tag, sel ? w_out1 : w_out0, exp);
  endtask

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(P_F, rop(), 1'($urandom), 1'b0, "reset");
  endtask

  // op is scrambled everywhere except DECODE and MEMADR, where it is sampled
  task automatic run_instr(input logic [6:0] opv, input int wf, input int wm);
    for (int i = 0; i < wf; i++) cyc(P_F, rop(), 1'b0, 1'b1, "fetch_wait");
    cyc(P_F, rop(), 1'b1, 1'b1, "fetch");
    cyc(P_D, opv, 1'($urandom), 1'b1, "decode");
    if (legal(opv)) begin
      case (opv)
        LW: begin
          cyc(P_MA, opv, 1'($urandom), 1'b1, "memadr");
          for (int i = 0; i < wm; i++) cyc(P_MR, rop(), 1'b0, 1'b1, "memread_wait");
          cyc(P_MR, rop(), 1'b1, 1'b1, "memread");
          cyc(P_MWB, rop(), 1'($urandom), 1'b1, "memwb");
        end
        SW: begin
          cyc(P_MA, opv, 1'($urandom), 1'b1, "memadr");
          for (int i = 0; i < wm; i++) cyc(P_MW, rop(), 1'b0, 1'b1, "memwrite_wait");
          cyc(P_MW, rop(), 1'b1, 1'b1, "memwrite");
        end
        RT: begin
          cyc(P_EXR, rop(), 1'($urandom), 1'b1, "execr");
          cyc(P_AWB, rop(), 1'($urandom), 1'b1, "aluwb");
        end
        IT: begin
          cyc(P_EXI, rop(), 1'($urandom), 1'b1, "execi");
          cyc(P_AWB, rop(), 1'($urandom), 1'b1, "aluwb");
        end
        BQ: cyc(P_BEQ, rop(), 1'($urandom), 1'b1, "beq");
        JL: begin
          cyc(P_JAL, rop(), 1'($urandom), 1'b1, "jal");
          cyc(P_AWB, rop(), 1'($urandom), 1'b1, "aluwb");
        end
        default: ;
      endcase
    end
  endtask

  task automatic run_random(input int n);
    logic [6:0] opv;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 7))
        0: opv = LW;
        1: opv = SW;
        2: opv = RT;
        3: opv = IT;
        4: opv = BQ;
        5: opv = JL;
        6: opv = 7'h00;
        default: opv = rop();
      endcase
      run_instr(opv, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    bus0.op = 7'h00; bus0.mem_ready = 1'b0;
    bus1.op = 7'h00; bus1.mem_ready = 1'b0;

    sel = 1'b0;
    do_reset(2);
    run_instr(LW, 0, 0);
    run_instr(SW, 0, 3);
    run_instr(RT, 0, 0);
    run_instr(IT, 1, 0);
    run_instr(BQ, 0, 0);
    run_instr(JL, 0, 0);
    run_instr(7'h00, 0, 0);

    // reset while a load is stalled on memory
    cyc(P_F, rop(), 1'b1, 1'b1, "fetch");
    cyc(P_D, LW, 1'b1, 1'b1, "decode");
    cyc(P_MA, LW, 1'b1, 1'b1, "memadr");
    cyc(P_MR, rop(), 1'b0, 1'b1, "memread_wait");
    cyc(P_MR, rop(), 1'b0, 1'b1, "memread_wait");
    do_reset(2);
    run_instr(LW, 0, 0);

    run_random(60);

    sel = 1'b1;
    do_reset(2);
    run_instr(IT, 0, 0);
    run_instr(JL, 0, 0);
    run_instr(7'h00, 0, 0);
    run_instr(LW, 1, 2);
    run_random(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
